// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the riscv_hart buses: a registered single-cycle fetch
// port and a valid/ready data port with configurable wait states and fault responses.
module riscv_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instruction,
    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic [2:0]            mem_funct3,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_read,
    output logic                  mem_fault
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;

    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [1:0]            lane_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  fault_q;

    logic [DATA_WIDTH-1:0] instruction_q;
    logic [DATA_WIDTH-1:0] mem_read_q;
    logic                  mem_ready_q;
    logic                  mem_fault_q;

    logic                  accept;
    logic                  fire;
    logic                  commit;

    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [1:0]            req_lane;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_fault;

    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] store_data;
    logic [3:0]            store_be;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{pc[1:0], pc[ADDR_WIDTH-1:IDX_W+2], mem_addr[ADDR_WIDTH-1:IDX_W+2]};

    function automatic logic decode_fault(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    decode_fault = 1'b0;
            F3_H:    decode_fault = lane[0];
            F3_W:    decode_fault = (lane != 2'b00);
            F3_BU:   decode_fault = wr;
            F3_HU:   decode_fault = wr | lane[0];
            default: decode_fault = 1'b1;
        endcase
    endfunction

    // With LATENCY=0 the response fires on the accept edge itself, so the live
    // inputs stand in for the not-yet-captured request while in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_write  = mem_write;
            req_funct3 = mem_funct3;
            req_lane   = mem_addr[1:0];
            req_idx    = mem_addr[IDX_W+1:2];
            req_data   = mem_data;
            req_fault  = decode_fault(mem_write, mem_funct3, mem_addr[1:0]);
        end else begin
            req_write  = write_q;
            req_funct3 = funct3_q;
            req_lane   = lane_q;
            req_idx    = idx_q;
            req_data   = data_q;
            req_fault  = fault_q;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign fire   = (state_d == ST_RESP);
    assign commit = fire & req_write & ~req_fault;

    always_comb begin
        rd_word = mem[req_idx];
        rd_byte = rd_word[{req_lane, 3'b000} +: 8];
        rd_half = rd_word[{req_lane[1], 4'b0000} +: 16];
        case (req_funct3)
            F3_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_val = {{16{rd_half[15]}}, rd_half};
            F3_BU:   load_val = {24'd0, rd_byte};
            F3_HU:   load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                store_data = {4{req_data[7:0]}};
                store_be   = 4'b0001 << req_lane;
            end
            2'b01: begin
                store_data = {2{req_data[15:0]}};
                store_be   = req_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = req_data;
                store_be   = 4'b1111;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            instruction_q <= '0;
            mem_read_q    <= '0;
            mem_ready_q   <= 1'b0;
            mem_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            instruction_q <= mem[pc[IDX_W+1:2]];
            mem_ready_q   <= fire;
            mem_fault_q   <= fire & req_fault;
            if (fire) begin
                if (req_fault)      mem_read_q <= '0;
                else if (!req_write) mem_read_q <= load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= mem_write;
            funct3_q <= mem_funct3;
            lane_q   <= mem_addr[1:0];
            idx_q    <= mem_addr[IDX_W+1:2];
            data_q   <= mem_data;
            fault_q  <= decode_fault(mem_write, mem_funct3, mem_addr[1:0]);
        end
    end

    // NOTE: the storage array is deliberately not reset; it behaves as RAM and is preloaded by its user.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) mem[req_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    assign instruction = instruction_q;
    assign mem_read    = mem_read_q;
    assign mem_ready   = mem_ready_q;
    assign mem_fault   = mem_fault_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench: a zero-wait-state and a three-wait-state responder run
// against a byte-level reference memory kept in the bench.
module tb_riscv_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        valid_0, valid_3;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    logic [31:0] instr_0, instr_3;
    logic        ready_0, ready_3;
    logic [31:0] read_0, read_3;
    logic        fault_0, fault_3;

    int passed = 0;
    int total  = 0;

    // Reference: byte-addressed storage per instance plus the last load/fault value.
    logic [7:0]  mb [2][1024];
    logic [31:0] last_read [2];

    riscv_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instr_0),
        .mem_valid(valid_0), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(ready_0), .mem_read(read_0), .mem_fault(fault_0)
    );

    riscv_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instr_3),
        .mem_valid(valid_3), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(ready_3), .mem_read(read_3), .mem_fault(fault_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_0 : ready_3;
    endfunction

    function automatic logic get_fault(input int sel);
        return (sel == 0) ? fault_0 : fault_3;
    endfunction

    function automatic logic [31:0] get_read(input int sel);
        return (sel == 0) ? read_0 : read_3;
    endfunction

    function automatic logic [31:0] get_instr(input int sel);
        return (sel == 0) ? instr_0 : instr_3;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid_0 = v;
        else          valid_3 = v;
    endtask

    function automatic logic [31:0] model_word(input int sel, input logic [31:0] addr);
        int base;
        base = int'(addr % 1024) / 4 * 4;
        return {mb[sel][base+3], mb[sel][base+2], mb[sel][base+1], mb[sel][base]};
    endfunction

    // Applies one data-port access to the reference and returns the expected response.
    function automatic void ref_access(input int sel, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] data,
                                       output logic flt, output logic [31:0] rd);
        int     base, off, n;
        longint val;
        base = int'(addr % 1024);
        off  = base % 4;
        n    = 1 << f3[1:0];
        flt  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wr && f3 >= 4) ||
               (n == 2 && off % 2 != 0) || (n == 4 && off != 0);
        if (flt) begin
            rd = 32'd0;
            last_read[sel] = rd;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mb[sel][base+k] = data[8*k +: 8];
            rd = last_read[sel];
        end else begin
            val = 0;
            for (int k = 0; k < n; k++) val += longint'(mb[sel][base+k]) << (8*k);
            if (!f3[2] && n < 4 && val >= (longint'(1) << (8*n-1))) val -= (longint'(1) << (8*n));
            rd = 32'(val);
            last_read[sel] = rd;
        end
    endfunction

    task automatic do_req(input int sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input string name, output logic [31:0] got);
        logic        exp_fault;
        logic [31:0] exp_read;
        int          n;
        ref_access(sel, wr, f3, addr, data, exp_fault, exp_read);
        @(negedge clk);
        mem_write  = wr;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_data   = data;
        set_valid(sel, 1'b1);
        @(negedge clk);
        set_valid(sel, 1'b0);
        n = 1;
        while (get_ready(sel) !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (get_ready(sel) !== 1'b1 || n != lat_of(sel) + 1)
            $display("FAIL %s latency: got %0d cycles (ready=%b), want %0d", name, n, get_ready(sel), lat_of(sel) + 1);
        else passed++;
        got = get_read(sel);
        total++;
        if (get_fault(sel) !== exp_fault)
            $display("FAIL %s fault: got %b, want %b", name, get_fault(sel), exp_fault);
        else passed++;
        total++;
        if (got !== exp_read)
            $display("FAIL %s read: got %h, want %h", name, got, exp_read);
        else passed++;
        @(negedge clk);
        total++;
        if (get_ready(sel) !== 1'b0 || get_fault(sel) !== 1'b0)
            $display("FAIL %s pulse: got ready=%b fault=%b, want 0/0", name, get_ready(sel), get_fault(sel));
        else passed++;
    endtask

    task automatic check_outputs_zero(input string name);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (get_ready(s) !== 1'b0 || get_fault(s) !== 1'b0 || get_read(s) !== 32'd0 || get_instr(s) !== 32'd0)
                $display("FAIL %s dut%0d outputs: got ready=%b fault=%b read=%h instr=%h, want all 0",
                         name, s, get_ready(s), get_fault(s), get_read(s), get_instr(s));
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        last_read[0] = 32'd0;
        last_read[1] = 32'd0;
        rst = 1'b1;
    endtask

    task automatic init_memory();
        logic [31:0] got;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                do_req(s, 1'b1, 3'b010, 32'(i * 4), $urandom, "init", got);
    endtask

    task automatic test_word_lat0();
        logic [31:0] got;
        do_req(0, 1'b1, 3'b010, 32'h0C, 32'd42, "sw_0c", got);
        do_req(0, 1'b0, 3'b010, 32'h0C, 32'd0, "lw_0c", got);
        total++;
        if (got !== 32'd42) $display("FAIL lw_0c value: got %0d, want 42", got);
        else passed++;
    endtask

    task automatic test_byte_half();
        logic [31:0] got;
        do_req(0, 1'b1, 3'b010, 32'h08, 32'h11223344, "sw_08", got);
        do_req(0, 1'b1, 3'b000, 32'h09, 32'h000000F0, "sb_09", got);
        do_req(0, 1'b0, 3'b000, 32'h09, 32'd0, "lb_09", got);
        total++;
        if (got !== 32'hFFFFFFF0) $display("FAIL lb_09 value: got %h, want fffffff0", got);
        else passed++;
        do_req(0, 1'b0, 3'b100, 32'h09, 32'd0, "lbu_09", got);
        total++;
        if (got !== 32'h000000F0) $display("FAIL lbu_09 value: got %h, want 000000f0", got);
        else passed++;
        do_req(0, 1'b0, 3'b001, 32'h0A, 32'd0, "lh_0a", got);
        total++;
        if (got !== 32'h00001122) $display("FAIL lh_0a value: got %h, want 00001122", got);
        else passed++;
        do_req(0, 1'b0, 3'b010, 32'h08, 32'd0, "lw_08", got);
        total++;
        if (got !== 32'h1122F044) $display("FAIL word2 value: got %h, want 1122f044", got);
        else passed++;
        do_req(1, 1'b1, 3'b001, 32'h32, 32'h0000ABCD, "lat3_sh", got);
        do_req(1, 1'b0, 3'b101, 32'h32, 32'd0, "lat3_lhu", got);
        do_req(1, 1'b0, 3'b001, 32'h32, 32'd0, "lat3_lh", got);
    endtask

    task automatic test_faults();
        logic [31:0] got;
        for (int s = 0; s < 2; s++) begin
            do_req(s, 1'b0, 3'b010, 32'h06, 32'd0, "flt_lw06", got);
            do_req(s, 1'b1, 3'b001, 32'h03, 32'hBEEF, "flt_sh03", got);
            do_req(s, 1'b1, 3'b100, 32'h10, 32'h55, "flt_st100", got);
            do_req(s, 1'b0, 3'b011, 32'h00, 32'd0, "flt_f3_011", got);
            do_req(s, 1'b0, 3'b110, 32'h00, 32'd0, "flt_f3_110", got);
            do_req(s, 1'b0, 3'b101, 32'h05, 32'd0, "flt_lhu05", got);
            do_req(s, 1'b0, 3'b010, 32'h00, 32'd0, "after_flt_w0", got);
            do_req(s, 1'b0, 3'b010, 32'h04, 32'd0, "after_flt_w1", got);
            do_req(s, 1'b0, 3'b010, 32'h10, 32'd0, "after_flt_w4", got);
        end
    endtask

    task automatic test_handoff();
        logic        flt;
        logic [31:0] exp_read;
        logic        exp_ready;
        ref_access(1, 1'b0, 3'b010, 32'h0C, 32'd0, flt, exp_read);
        @(negedge clk);
        mem_write  = 1'b0;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h0C;
        valid_3    = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            exp_ready = (n == 4) || (n == 9);
            total++;
            if (ready_3 !== exp_ready)
                $display("FAIL handoff cycle %0d ready: got %b, want %b", n, ready_3, exp_ready);
            else passed++;
            if (exp_ready) begin
                total++;
                if (read_3 !== exp_read || fault_3 !== 1'b0)
                    $display("FAIL handoff cycle %0d data: got %h/%b, want %h/0", n, read_3, fault_3, exp_read);
                else passed++;
            end
            if (n == 9) valid_3 = 1'b0;
        end
    endtask

    task automatic test_fetch();
        logic [31:0] got;
        logic [31:0] pcs  [4];
        logic [31:0] want [4];
        do_req(0, 1'b1, 3'b010, 32'h0, 32'h02A00293, "pre_w0", got);
        do_req(0, 1'b1, 3'b010, 32'h4, 32'h04D00093, "pre_w1", got);
        pcs  = '{32'h0, 32'h4, 32'h400, 32'h407};
        want = '{32'h02A00293, 32'h04D00093, 32'h02A00293, 32'h04D00093};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc = pcs[i];
            @(negedge clk);
            total++;
            if (instr_0 !== want[i]) $display("FAIL fetch pc=%h: got %h, want %h", pcs[i], instr_0, want[i]);
            else passed++;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            pc = $urandom;
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                total++;
                if (get_instr(s) !== model_word(s, pc))
                    $display("FAIL fetch_rand dut%0d pc=%h: got %h, want %h", s, pc, get_instr(s), model_word(s, pc));
                else passed++;
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_word, new_word;
        logic        flt;
        logic [31:0] rd;
        old_word = model_word(0, 32'h20);
        new_word = ~old_word;
        ref_access(0, 1'b1, 3'b010, 32'h20, new_word, flt, rd);
        @(negedge clk);
        pc         = 32'h20;
        mem_write  = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h20;
        mem_data   = new_word;
        valid_0    = 1'b1;
        @(negedge clk);
        valid_0 = 1'b0;
        total++;
        if (instr_0 !== old_word || ready_0 !== 1'b1)
            $display("FAIL collision same-edge: got instr=%h ready=%b, want %h/1", instr_0, ready_0, old_word);
        else passed++;
        @(negedge clk);
        total++;
        if (instr_0 !== new_word) $display("FAIL collision next: got %h, want %h", instr_0, new_word);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        do_req(1, 1'b1, 3'b010, 32'h10, 32'd7, "pre_w4", got);
        @(negedge clk);
        mem_write  = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h10;
        mem_data   = 32'hDEADBEEF;
        valid_3    = 1'b1;
        @(negedge clk);
        valid_3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_mid");
        last_read[0] = 32'd0;
        last_read[1] = 32'd0;
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total++;
            if (ready_3 !== 1'b0 || ready_0 !== 1'b0)
                $display("FAIL reset_mid stray ready: got %b/%b, want 0/0", ready_0, ready_3);
            else passed++;
        end
        do_req(1, 1'b0, 3'b010, 32'h10, 32'd0, "post_rst_lw", got);
        total++;
        if (got !== 32'd7) $display("FAIL post_rst word: got %h, want 00000007", got);
        else passed++;
        do_req(1, 1'b1, 3'b010, 32'h10, 32'h12345678, "post_rst_sw", got);
        do_req(1, 1'b0, 3'b010, 32'h10, 32'd0, "post_rst_lw2", got);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, "post_rst_lat0", got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int i = 0; i < 120; i++) begin
            int          sel;
            logic [2:0]  f3;
            logic [31:0] addr;
            sel  = int'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            do_req(sel, 1'($urandom_range(0, 1)), f3, addr, $urandom, "random", got);
        end
    endtask

    initial begin
        pc         = 32'd0;
        valid_0    = 1'b0;
        valid_3    = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'b010;
        mem_addr   = 32'd0;
        mem_data   = 32'd0;
        test_reset();
        init_memory();
        test_word_lat0();
        test_byte_half();
        test_faults();
        test_handoff();
        test_fetch();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Memory-side responder for the riscv_hart instruction and data buses. It is the other end of the hart's fetch and load/store interface.
- Instruction port: single-cycle registered fetch.
- Data port: valid/ready handshake with a configurable wait-state count, byte/halfword/word access by funct3, and a fault response for misaligned or illegal accesses.
- Used as the standard memory model in hart testbenches and as the on-chip RAM in small SoC builds.

Parameters:
- ADDR_WIDTH, 32, byte-address width of pc and mem_addr.
- DATA_WIDTH, 32, word width. Only 32 is supported.
- DEPTH, 256, number of 32-bit words of storage. Must be a power of two.
- LATENCY, 0, data-port wait states, range 0..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous active-low reset.
- pc  in  ADDR_WIDTH  instruction fetch byte address.
- instruction  out  32  fetched word, registered.
- mem_valid  in  1  data request strobe.
- mem_write  in  1  1 = store, 0 = load. Sampled with mem_valid.
- mem_funct3  in  3  access size/sign (RV32I load/store funct3).
- mem_addr  in  ADDR_WIDTH  data byte address.
- mem_data  in  32  store data. Lane 0 is right-aligned.
- mem_ready  out  1  one-cycle response pulse.
- mem_read  out  32  load result, sign/zero-extended.
- mem_fault  out  1  qualifies mem_ready: access rejected.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low: rst low at a rising edge resets the block.
  - On reset: instruction=0, mem_read=0, mem_ready=0, mem_fault=0, FSM=IDLE, wait counter=0.
  - Storage array "mem" is NOT cleared by reset. Benches preload it hierarchically.
- Addressing:
  - Word index = addr[$clog2(DEPTH)+1:2]. Higher bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = addr[1:0].
- Fetch port:
  - Every non-reset cycle: instruction <= mem[index(pc)]. Latency is 1 cycle and there are no wait states.
  - pc[1:0] is ignored.
- Data FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_valid is sampled only in this state.
  - When mem_valid=1, the block captures mem_write, mem_funct3, mem_addr and mem_data.
  - A fault is decoded at capture:
    - halfword access with addr[0]=1;
    - word access with addr[1:0]!=0;
    - funct3 in {011, 110, 111};
    - a store with funct3 100 or 101.
  - If LATENCY=0, go to RESP. Otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter=0, go to RESP.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - mem_valid is ignored in this cycle. The FSM returns unconditionally to IDLE.
- Timing:
  - A request accepted in cycle T has mem_ready high in cycle T+1+LATENCY.
  - Minimum issue interval is LATENCY+2 cycles.
- Store commit:
  - Occurs at the RESP edge, and only when there is no fault.
  - SB writes byte lane addr[1:0] with mem_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with mem_data[15:0].
  - SW writes the whole word.
  - Other bytes are untouched.
  - mem_read is held at its previous value for stores.
- Load result:
  - Presented with mem_ready and held until the next load or fault response.
  - LB / LH: sign-extended.
  - LBU / LHU: zero-extended.
  - LW: raw word.
  - Memory is read at the RESP edge, so it reflects every commit before that edge.
- Fault:
  - mem_fault=1 together with mem_ready.
  - No memory change. mem_read <= 0.
  - mem_fault is 0 in every cycle where mem_ready=0.
- Fetch/store collision: if a fetch and a committing store target the same word in the same cycle, instruction returns the pre-store contents (read-before-write).
- Reset mid-operation: the pending request is dropped and never committed, and no mem_ready is produced. The FSM is in IDLE on the first cycle with rst high.

Test Plan:
1. LATENCY=0:
   - SW addr 0x0C, data 42, then LW 0x0C.
   - Required: mem_ready one cycle after each accept; load returns 42; mem_fault=0.
2. Byte and halfword access:
   - Preload word 2 = 0x11223344. Then SB addr 0x09 data 0xF0, followed by LB 0x09, LBU 0x09, LH 0x0A.
   - Required: word 2 = 0x1122F044; LB = 0xFFFFFFF0; LBU = 0x000000F0; LH = 0x00001122.
3. Faults:
   - LW 0x06, SH 0x03, and a store with funct3 100.
   - Required: each returns mem_ready with mem_fault=1 and mem_read=0; memory unchanged.
4. Wait states and hand-off:
   - LATENCY=3: accept at cycle T gives mem_ready at T+4.
   - mem_valid held high through WAIT and RESP must not start a second request until IDLE.
5. Fetch port:
   - Preload words 0 and 1 with 0x02A00293 and 0x04D00093. Drive pc 0, then pc 4.
   - Required: instruction shows each word one cycle later. pc 0x400 aliases to word 0.
6. Reset mid-operation:
   - Drop rst low during WAIT of an SW to 0x10 (old value 7).
   - Required: no mem_ready, word at 0x10 stays 7, all outputs 0, next request is serviced normally.
